// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: control-FSM state
// encoding, default register-address width, NOP encoding and the width of the
// multiply/divide down-counter.
package pipe_ctrl_pkg;

  // Default register-address width (32 architectural registers).
  localparam int REG_W_DEF = 5;

  // Instruction word loaded into IF/ID on a flush (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Multiply/divide latency is at most 15 cycles, so 4 bits hold MD_LAT-1.
  localparam int MD_CNT_W = 4;

  // Control FSM states.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    MDWAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/reg_match.sv
// Single source-versus-stage register compare. A hit needs the source to be
// in use, the stage to be writing, equal register numbers, and a non-zero
// register (x0 is hard-wired and never creates a dependency).
module reg_match #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_src,
  input  logic             i_use,
  input  logic [REG_W-1:0] i_dst,
  input  logic             i_we,
  output logic             o_match
);

  // Pure combinational compare.
  always_comb begin
    o_match = i_use && i_we && (i_src == i_dst) && (i_src != '0);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls ID on read-after-write hazards, flushes
// IF/ID on a taken branch, and freezes the front end while a multiply/divide
// occupies EX for MD_LAT cycles. Counts stall cycles (saturating).
// Build option: define HAZARD_FORWARD_EN when MEM/WB results are forwarded,
// so only a load in EX feeding ID causes a stall.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [1:0]       id_rs_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             ex_we,
  input  logic             mem_we,
  input  logic             wb_we,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             ex_md_start,
  output logic             id_ready,
  output logic             pc_hold,
  output logic             id_bubble,
  output logic             ifid_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Counter reload value: MD_LAT-1 down to 0 gives MD_LAT stall cycles.
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);

  hz_state_e           r_state;
  hz_state_e           w_state_next;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [MD_CNT_W-1:0] w_md_cnt_next;
  logic [CNT_W-1:0]    r_stall_cnt;

  // Compare operands arranged so instance gi checks source gi%2 against
  // stage gi/2 (stage 0 = EX, 1 = MEM, 2 = WB).
  logic [REG_W-1:0] w_src [2];
  logic [REG_W-1:0] w_dst [3];
  logic [2:0]       w_we;
  logic [5:0]       w_match;
  logic             w_ex_hit;
  logic             w_mem_hit;
  logic             w_wb_hit;
  logic             w_load_use;
  logic             w_raw_haz;

  assign w_src[0] = id_rs1;
  assign w_src[1] = id_rs2;
  assign w_dst[0] = ex_rd;
  assign w_dst[1] = mem_rd;
  assign w_dst[2] = wb_rd;
  assign w_we     = {wb_we, mem_we, ex_we};

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_match
      reg_match #(
        .REG_W (REG_W)
      ) u_reg_match (
        .i_src   (w_src[gi % 2]),
        .i_use   (id_rs_valid[gi % 2]),
        .i_dst   (w_dst[gi / 2]),
        .i_we    (w_we[gi / 2]),
        .o_match (w_match[gi])
      );
    end
  endgenerate

  // Reduce per-source compares into per-stage hits and the hazard decision.
  always_comb begin
    w_ex_hit   = w_match[0] | w_match[1];
    w_mem_hit  = w_match[2] | w_match[3];
    w_wb_hit   = w_match[4] | w_match[5];
    w_load_use = ex_is_load & w_ex_hit;
`ifdef HAZARD_FORWARD_EN
    // MEM and WB values are forwarded; only load data is too late.
    w_raw_haz  = w_load_use;
`else
    // No forwarding: any in-flight writer of a source register stalls ID.
    // (A load-use is a subset of an EX hit.)
    w_raw_haz  = w_load_use | w_ex_hit | w_mem_hit | w_wb_hit;
`endif
  end

  // Next-state and control outputs; reset forces the flush/bubble pattern.
  always_comb begin
    w_state_next  = r_state;
    w_md_cnt_next = r_md_cnt;
    id_ready      = 1'b1;
    pc_hold       = 1'b0;
    id_bubble     = 1'b0;
    ifid_flush    = 1'b0;
    md_busy       = 1'b0;

    if (reset) begin
      id_bubble     = 1'b1;
      ifid_flush    = 1'b1;
      w_state_next  = RUN;
      w_md_cnt_next = '0;
    end else if (r_state == MDWAIT) begin
      // EX is frozen: a taken-branch indication here is ignored.
      md_busy   = 1'b1;
      id_ready  = 1'b0;
      pc_hold   = 1'b1;
      id_bubble = 1'b1;
      if (r_md_cnt == '0) begin
        w_state_next = RUN;
      end else begin
        w_md_cnt_next = r_md_cnt - 1'b1;
      end
    end else if (ex_br_taken) begin
      // Branch flush beats a hazard and drops a simultaneous mul/div start.
      ifid_flush   = 1'b1;
      id_bubble    = 1'b1;
      w_state_next = FLUSH;
    end else if (r_state == FLUSH) begin
      // The instruction in ID is a wrong-path NOP; hazards are irrelevant.
      id_bubble    = 1'b1;
      w_state_next = RUN;
    end else begin
      if (w_raw_haz) begin
        id_ready  = 1'b0;
        pc_hold   = 1'b1;
        id_bubble = 1'b1;
      end
      if (ex_md_start) begin
        w_md_cnt_next = MD_LOAD;
        w_state_next  = MDWAIT;
      end
    end
  end

  // State and mul/div counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_md_cnt <= w_md_cnt_next;
    end
  end

  // Saturating count of cycles in which ID did not accept a new instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (!id_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver applies one input vector per
// cycle and pushes the reference model's expected outputs; a monitor pops and
// compares on the falling edge. Directed scenarios first, then random traffic.
// Honours HAZARD_FORWARD_EN in the reference model.
module tb_pipe_hazard_ctrl;

  localparam int REG_W   = 5;
  localparam int MD_LAT  = 4;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic [1:0]       id_rs_valid;
  logic             ex_we, mem_we, wb_we, ex_is_load, ex_br_taken, ex_md_start;
  logic             id_ready, pc_hold, id_bubble, ifid_flush, md_busy;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(
    .REG_W  (REG_W),
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs_valid (id_rs_valid),
    .ex_rd       (ex_rd),
    .mem_rd      (mem_rd),
    .wb_rd       (wb_rd),
    .ex_we       (ex_we),
    .mem_we      (mem_we),
    .wb_we       (wb_we),
    .ex_is_load  (ex_is_load),
    .ex_br_taken (ex_br_taken),
    .ex_md_start (ex_md_start),
    .id_ready    (id_ready),
    .pc_hold     (pc_hold),
    .id_bubble   (id_bubble),
    .ifid_flush  (ifid_flush),
    .md_busy     (md_busy),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic             rdy;
    logic             hold;
    logic             bub;
    logic             fl;
    logic             busy;
    logic [CNT_W-1:0] sc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: stall cycles still owed to a mul/div, whether the
  // previous cycle was a branch flush, and stall cycles seen since reset.
  int md_left     = 0;
  bit flush_prev  = 0;
  int stalls      = 0;
  int cyc         = 0;

  // Does any used, non-zero source collide with a writing downstream stage?
  function automatic bit model_haz(
    input logic [REG_W-1:0] r1, input logic [REG_W-1:0] r2, input logic [1:0] v,
    input logic [REG_W-1:0] erd, input logic [REG_W-1:0] mrd, input logic [REG_W-1:0] wrd,
    input bit ewe, input bit mwe, input bit wwe, input bit ld);
    logic [REG_W-1:0] srcs [2];
    logic [REG_W-1:0] dsts [3];
    bit               wes  [3];
    bit               hit;
    srcs = '{r1, r2};
    dsts = '{erd, mrd, wrd};
    wes  = '{ewe, mwe, wwe};
    hit  = 0;
    for (int s = 0; s < 2; s++) begin
      for (int t = 0; t < 3; t++) begin
        if (v[s] && srcs[s] != 0 && srcs[s] == dsts[t] && wes[t]) begin
`ifdef HAZARD_FORWARD_EN
          if (t == 0 && ld) hit = 1;
`else
          hit = 1;
`endif
        end
      end
    end
    return hit;
  endfunction

  // Apply one cycle of inputs and queue the expected outputs for that cycle.
  task automatic step(
    input bit rst, input logic [REG_W-1:0] r1, input logic [REG_W-1:0] r2,
    input logic [1:0] v, input logic [REG_W-1:0] erd, input logic [REG_W-1:0] mrd,
    input logic [REG_W-1:0] wrd, input bit ewe, input bit mwe, input bit wwe,
    input bit ld, input bit br, input bit md);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_rs1 = r1; id_rs2 = r2; id_rs_valid = v;
    ex_rd = erd; mem_rd = mrd; wb_rd = wrd;
    ex_we = ewe; mem_we = mwe; wb_we = wwe;
    ex_is_load = ld; ex_br_taken = br; ex_md_start = md;

    e.cyc = cyc;
    e.sc  = CNT_W'(stalls);
    e.rdy = 1; e.hold = 0; e.bub = 0; e.fl = 0; e.busy = 0;
    if (rst) begin
      e.bub = 1; e.fl = 1;
      md_left = 0; flush_prev = 0;
    end else if (md_left > 0) begin
      e.rdy = 0; e.hold = 1; e.bub = 1; e.busy = 1;
      md_left--;
    end else if (br) begin
      e.fl = 1; e.bub = 1;
      flush_prev = 1;
    end else if (flush_prev) begin
      e.bub = 1;
      flush_prev = 0;
    end else begin
      if (model_haz(r1, r2, v, erd, mrd, wrd, ewe, mwe, wwe, ld)) begin
        e.rdy = 0; e.hold = 1; e.bub = 1;
      end
      if (md) md_left = MD_LAT;
    end
    if (rst) stalls = 0;
    else if (!e.rdy && stalls < CNT_MAX) stalls++;
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int c, input logic [CNT_W-1:0] got,
                     input logic [CNT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cyc %0d %s: got %0d expected %0d", c, name, got, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("id_ready",   e.cyc, CNT_W'(id_ready),   CNT_W'(e.rdy));
        chk("pc_hold",    e.cyc, CNT_W'(pc_hold),    CNT_W'(e.hold));
        chk("id_bubble",  e.cyc, CNT_W'(id_bubble),  CNT_W'(e.bub));
        chk("ifid_flush", e.cyc, CNT_W'(ifid_flush), CNT_W'(e.fl));
        chk("md_busy",    e.cyc, CNT_W'(md_busy),    CNT_W'(e.busy));
        chk("stall_cnt",  e.cyc, stall_cnt,          e.sc);
        $display("cyc %0d rst=%b br=%b md=%b -> rdy=%b hold=%b bub=%b fl=%b busy=%b sc=%0d",
                 e.cyc, reset, ex_br_taken, ex_md_start, id_ready, pc_hold,
                 id_bubble, ifid_flush, md_busy, stall_cnt);
      end
    end
  end

  initial begin
    reset = 1; id_rs1 = 0; id_rs2 = 0; id_rs_valid = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_we = 0; mem_we = 0; wb_we = 0;
    ex_is_load = 0; ex_br_taken = 0; ex_md_start = 0;
    repeat (2) @(posedge clk);

    // Reset outputs, then load-use on rs1 = x3.
    step(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 3, 0, 2'b01, 3, 0, 0, 1, 0, 0, 1, 0, 0);
    idle(1);
    // rs2 = x7 written by a non-load in MEM.
    step(0, 0, 7, 2'b10, 0, 7, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    // x0 never hazards.
    step(0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    // Mul/div with a branch pulse in its second stall cycle.
    step(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(4);
    // Branch together with load-use and a mul/div start.
    step(0, 3, 0, 2'b01, 3, 0, 0, 1, 0, 0, 1, 1, 1);
    step(0, 3, 0, 2'b01, 3, 0, 0, 1, 0, 0, 1, 0, 0);
    idle(2);
    // Reset in the second mul/div stall cycle.
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    step(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Random traffic; small register range makes collisions frequent, and
    // rare resets let the 6-bit stall counter reach saturation.
    for (int i = 0; i < 900; i++) begin
      step($urandom_range(0, 149) == 0,
           REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)),
           REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)),
           REG_W'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
